// File: rtl/key_scan_encoder.sv
// key_scan_encoder
//   Scans a 4x4 active-low keypad one row at a time, debounces the result
//   over whole scans and presents the accepted key as a 4-bit code with a
//   valid/acknowledge handshake.
//
// Ports
//   CLK       single clock, rising edge
//   RST       synchronous active-high reset
//   COL[3:0]  keypad columns, active-low, asynchronous to CLK
//   ACK       consumer acknowledge of CODE
//   ROW[3:0]  row drive, active-low one-hot
//   CODE[3:0] accepted key number 4*row + col
//   VALID     CODE holds an unacknowledged key
//   KEY_DOWN  an accepted key is currently held
//   OVR       sticky: a key was accepted while VALID was still set
//
// State table
//   state    | meaning
//   IDLE     | no key held, waiting for a scan that sees a key
//   DEBOUNCE | same candidate key seen on cnt consecutive scans
//   HELD     | key accepted, waiting for a scan with no key
//   RELEASE  | no key seen on cnt consecutive scans since HELD

module key_scan_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_N    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COL,
  input  logic       ACK,
  output logic [3:0] ROW,
  output logic [3:0] CODE,
  output logic       VALID,
  output logic       KEY_DOWN,
  output logic       OVR
);

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_LAST   = 4'(DEB_N);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] cand, cand_nxt;
  logic       accept;
  logic [3:0] accept_key;

  logic [3:0] col_s1, col_s2;
  logic [7:0] dwell;
  logic [1:0] row_idx;
  logic       last_dwell;
  logic       end_scan;

  logic [3:0] col_low;
  logic       row_hit;
  logic [1:0] row_col;

  logic       scan_any_q;
  logic [3:0] scan_key_q;
  logic       fin_any;
  logic [3:0] fin_key;

  // Column synchronizer; idle level is all-high (no key).
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= COL;
      col_s2 <= col_s1;
    end
  end

  // Row dwell timer and row index.
  assign last_dwell = (dwell == DWELL_LAST);
  assign end_scan   = last_dwell && (row_idx == 2'd3);

  always_ff @(posedge CLK) begin
    if (RST) begin
      dwell   <= 8'd0;
      row_idx <= 2'd0;
    end else if (last_dwell) begin
      dwell   <= 8'd0;
      row_idx <= row_idx + 2'd1;
    end else begin
      dwell   <= dwell + 8'd1;
    end
  end

  assign ROW = ~(4'b0001 << row_idx);

  // Lowest pressed column on the current row.
  assign col_low = ~col_s2;
  assign row_hit = |col_low;

  always_comb begin
    row_col = 2'd0;
    if (col_low[3]) row_col = 2'd3;
    if (col_low[2]) row_col = 2'd2;
    if (col_low[1]) row_col = 2'd1;
    if (col_low[0]) row_col = 2'd0;
  end

  // Rows are visited in ascending order, so the first hit of a scan is
  // always the lowest key number; later hits are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_any_q <= 1'b0;
      scan_key_q <= 4'd0;
    end else if (end_scan) begin
      scan_any_q <= 1'b0;
      scan_key_q <= 4'd0;
    end else if (last_dwell && row_hit && !scan_any_q) begin
      scan_any_q <= 1'b1;
      scan_key_q <= {row_idx, row_col};
    end
  end

  // Scan result including the row-3 sample taken on this very clock.
  assign fin_any = scan_any_q | row_hit;
  assign fin_key = scan_any_q ? scan_key_q : {row_idx, row_col};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cand  <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    accept     = 1'b0;
    accept_key = cand;
    if (end_scan) begin
      case (state)
        IDLE: begin
          if (fin_any) begin
            if (DEB_N == 1) begin
              accept     = 1'b1;
              accept_key = fin_key;
              state_nxt  = HELD;
              cnt_nxt    = 4'd0;
            end else begin
              state_nxt  = DEBOUNCE;
              cand_nxt   = fin_key;
              cnt_nxt    = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (fin_any && (fin_key == cand)) begin
            if ((cnt + 4'd1) == DEB_LAST) begin
              accept     = 1'b1;
              accept_key = cand;
              state_nxt  = HELD;
              cnt_nxt    = 4'd0;
            end else begin
              cnt_nxt    = cnt + 4'd1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        HELD: begin
          if (!fin_any) begin
            // With single-scan release the first empty scan already counts
            // as a full release.
            if (DEB_N == 1) begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
            end else begin
              state_nxt = RELEASE;
              cnt_nxt   = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (!fin_any) begin
            if ((cnt + 4'd1) == DEB_LAST) begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt   = cnt + 4'd1;
            end
          end else begin
            state_nxt = HELD;
            cnt_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign KEY_DOWN = (state == HELD) || (state == RELEASE);

  // Output handshake. An accept wins over ACK, so an accept on the same
  // clock as ACK keeps VALID set and is not an overrun.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CODE  <= 4'd0;
      VALID <= 1'b0;
      OVR   <= 1'b0;
    end else if (accept) begin
      CODE  <= accept_key;
      VALID <= 1'b1;
      if (VALID && !ACK) OVR <= 1'b1;
    end else if (ACK && VALID) begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_scan_encoder.sv
// tb_key_scan_encoder
//   Keypad model drives COL from ROW and a pressed-key mask. Each expected
//   accept is queued when the key is pressed and checked when KEY_DOWN rises.

module tb_key_scan_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ACK = 1'b0;
  logic [3:0]  COL;
  logic [3:0]  ROW;
  logic [3:0]  CODE;
  logic        VALID;
  logic        KEY_DOWN;
  logic        OVR;

  logic [15:0] keys = 16'h0000;

  typedef struct {
    logic [3:0] code;
    logic       valid;
    logic       ovr;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic kd_prev = 1'b0;

  always #5 CLK = ~CLK;

  key_scan_encoder #(.SCAN_DIV(4), .DEB_N(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .COL      (COL),
    .ACK      (ACK),
    .ROW      (ROW),
    .CODE     (CODE),
    .VALID    (VALID),
    .KEY_DOWN (KEY_DOWN),
    .OVR      (OVR)
  );

  always_comb begin
    COL = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!ROW[r])
        for (int c = 0; c < 4; c++)
          if (keys[4*r + c]) COL[c] = 1'b0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clocks since reset release; cycle 0 is the first cycle with RST low.
  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (KEY_DOWN && !kd_prev) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_accept", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("accept_code", CODE, e.code);
        check_val("accept_valid", VALID, e.valid);
        check_val("accept_ovr", OVR, e.ovr);
        if (e.cyc >= 0) check_val("accept_cyc", cyc, e.cyc);
      end
    end
    kd_prev = KEY_DOWN;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    tick(n);
    RST = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] code, input logic valid, input logic ovr, input int c);
    exp_t e;
    e.code  = code;
    e.valid = valid;
    e.ovr   = ovr;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_accepts(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_val("accept_timeout_pending", exp_q.size(), 0);
  endtask

  task automatic scan_align();
    while ((cyc % 16) != 0) tick(1);
  endtask

  task automatic ack_pulse();
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
  endtask

  task automatic release_keys();
    keys = 16'h0000;
    tick(80);
    check_val("key_down_released", KEY_DOWN, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] er;

    // Reset and row sequencing with no key.
    keys = 16'h0000;
    do_reset(2);
    for (int k = 0; k <= 16; k++) begin
      er = ~(4'b0001 << ((k / 4) % 4));
      check_val($sformatf("row_c%0d", k), ROW, er);
      tick(1);
    end
    check_val("rst_code", CODE, 4'd0);
    check_val("rst_valid", VALID, 1'b0);
    check_val("rst_key_down", KEY_DOWN, 1'b0);
    check_val("rst_ovr", OVR, 1'b0);

    // Clean press of key 6 held from reset release.
    keys = 16'h0040;
    do_reset(2);
    push_exp(4'd6, 1'b1, 1'b0, 48);
    wait_accepts(100);
    ack_pulse();
    check_val("ack_valid", VALID, 1'b0);
    check_val("ack_code", CODE, 4'd6);
    release_keys();

    // Bounce: key 6 on alternate scans never debounces.
    do_reset(2);
    for (int s = 0; s < 8; s++) begin
      keys = (s % 2 == 0) ? 16'h0040 : 16'h0000;
      tick(16);
    end
    keys = 16'h0000;
    tick(16);
    check_val("bounce_valid", VALID, 1'b0);
    check_val("bounce_key_down", KEY_DOWN, 1'b0);
    check_val("bounce_code", CODE, 4'd0);

    // Priority across rows (9 vs 5) and within a row (3 vs 2).
    keys = 16'h0220;
    do_reset(2);
    push_exp(4'd5, 1'b1, 1'b0, 48);
    wait_accepts(100);
    ack_pulse();
    release_keys();
    scan_align();
    keys = 16'h000C;
    push_exp(4'd2, 1'b1, 1'b0, -1);
    wait_accepts(100);
    ack_pulse();
    release_keys();

    // Overrun: second accept with VALID still set.
    keys = 16'h0040;
    do_reset(2);
    push_exp(4'd6, 1'b1, 1'b0, 48);
    wait_accepts(100);
    release_keys();
    check_val("ovr_valid_kept", VALID, 1'b1);
    scan_align();
    keys = 16'h0008;
    push_exp(4'd3, 1'b1, 1'b1, -1);
    wait_accepts(100);
    ack_pulse();
    check_val("ovr_ack_valid", VALID, 1'b0);
    check_val("ovr_sticky", OVR, 1'b1);
    check_val("ovr_code_kept", CODE, 4'd3);
    release_keys();

    // Accept on the same clock as ACK: VALID stays, no overrun.
    keys = 16'h0040;
    do_reset(2);
    push_exp(4'd6, 1'b1, 1'b0, 48);
    wait_accepts(100);
    release_keys();
    scan_align();
    keys = 16'h0004;
    push_exp(4'd2, 1'b1, 1'b0, -1);
    tick(47);
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
    wait_accepts(32);
    check_val("coinc_ovr", OVR, 1'b0);
    check_val("coinc_valid", VALID, 1'b1);
    release_keys();

    // Reset during DEBOUNCE restarts the debounce from scratch.
    keys = 16'h0040;
    do_reset(2);
    tick(32);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check_val("mid_rst_valid", VALID, 1'b0);
    push_exp(4'd6, 1'b1, 1'b0, 48);
    wait_accepts(100);
    keys = 16'h0000;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
